if_fetch: RTL

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction fetch stage with a 2-entry prefetch buffer.
//
// Issues one instruction-memory request at a time, buffers returned words
// together with their fall-through PC (addr+4), and presents the oldest entry
// to the IF/ID register. Redirects flush the buffer and restart fetch at the
// new target; a request already in flight when a redirect arrives is allowed
// to complete and its data is dropped.
//
// Ports
//   clk_i          clock, rising edge
//   rst_n_i        synchronous active-low reset
//   stall_i        ID hazard hold: head entry is not consumed this cycle
//   redirect_i     one-cycle branch/jump redirect pulse
//   redirect_pc_i  redirect target address
//   imem_req_o     instruction memory request
//   imem_addr_o    request address
//   imem_ack_i     memory response valid (may coincide with the request)
//   imem_data_i    instruction word, valid with imem_ack_i
//   valid_o        head entry present
//   pc_o           head entry PC+4 (0 when valid_o=0)
//   inst_o         head entry instruction (0 / NOP when valid_o=0)
//   flush_o        IF/ID flush, combinational copy of redirect_i
// ---------------------------------------------------------------------------
module if_fetch (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        flush_o
);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, wr_ptr_q;
    logic [31:0] fifo_pc_q   [2];
    logic [31:0] fifo_inst_q [2];

    logic        pop;
    logic        push;
    logic [1:0]  count_next;
    logic [31:0] req_addr_inc;

    assign valid_o      = (count_q != 2'd0);
    assign pop          = valid_o & ~stall_i & ~redirect_i;
    assign push         = (state_q == WAIT) & imem_ack_i & ~redirect_i;
    // A pop only happens when count_q>0, and a push only from WAIT where
    // count_q<=1, so this never underflows or exceeds 2.
    assign count_next   = count_q + {1'b0, push} - {1'b0, pop};
    // Wraps modulo 2^32 by construction of the 32-bit add.
    assign req_addr_inc = req_addr_q + 32'd4;

    assign imem_addr_o  = req_addr_q;
    assign flush_o      = redirect_i;
    // Gate the head with valid so stale buffer contents never leak out.
    assign pc_o         = valid_o ? fifo_pc_q[rd_ptr_q]   : 32'd0;
    assign inst_o       = valid_o ? fifo_inst_q[rd_ptr_q] : 32'd0;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        count_d    = redirect_i ? 2'd0 : count_next;
        imem_req_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_i;
                end else if (count_next <= 2'd1) begin
                    // Only issue when the buffer is guaranteed a free slot
                    // for the returning word.
                    req_addr_d = fetch_pc_q;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                imem_req_o = 1'b1;
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_i;
                    // Without an ack the request is still owed a response;
                    // DRAIN absorbs it so it cannot be mistaken for the target.
                    state_d    = imem_ack_i ? IDLE : DRAIN;
                end else if (imem_ack_i) begin
                    fetch_pc_d = req_addr_inc;
                    if (count_next <= 2'd1) begin
                        req_addr_d = req_addr_inc;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                imem_req_o = 1'b1;
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_i;
                end
                if (imem_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= 32'd0;
            req_addr_q <= 32'd0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            if (redirect_i) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                if (push) begin
                    wr_ptr_q <= ~wr_ptr_q;
                end
            end
        end
    end

    // Buffer storage carries no reset; its contents are only observed
    // through valid-gated outputs.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= req_addr_inc;
            fifo_inst_q[wr_ptr_q] <= imem_data_i;
        end
    end

endmodule
